// File: rtl/seq_div_unit.sv
// Multi-cycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, followed by a sign fix-up cycle.
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             calc_finished,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             sign_dvd_q, sign_dvd_d;
    logic             sign_dsr_q, sign_dsr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // rem_sh < 2*dsr, so the top bit of the difference is a clean borrow flag.
    assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dsr_q};
    assign rem_ge  = ~rem_sub[WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        sign_dvd_d = sign_dvd_q;
        sign_dsr_d = sign_dsr_q;
        zero_d     = zero_q;
        quot_d     = quot_q;
        rout_d     = rout_q;
        busy_d     = busy_q;
        done_d     = done_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sign_dvd_d = dividend[WIDTH-1];
                    sign_dsr_d = divisor[WIDTH-1];
                    zero_d     = (divisor == '0);
                    // Raw dividend kept for the divide-by-zero remainder.
                    dvd_d      = (divisor == '0) ? dividend : magnitude(dividend);
                    dsr_d      = magnitude(divisor);
                    rem_d      = '0;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    dbz_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ITER;
                end
            end
            ITER: begin
                if (zero_q) begin
                    quot_d  = '1;
                    rout_d  = dvd_q;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                quot_d  = (sign_dvd_q ^ sign_dsr_q) ? -dvd_q : dvd_q;
                rout_d  = sign_dvd_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            sign_dvd_q <= 1'b0;
            sign_dsr_q <= 1'b0;
            zero_q     <= 1'b0;
            quot_q     <= '0;
            rout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            sign_dvd_q <= sign_dvd_d;
            sign_dsr_q <= sign_dsr_d;
            zero_q     <= zero_d;
            quot_q     <= quot_d;
            rout_q     <= rout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign quotient      = quot_q;
    assign remainder     = rout_q;
    assign busy          = busy_q;
    assign calc_finished = done_q;
    assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed and randomized checks for seq_div_unit: signs, overflow, divide-by-zero,
// start-while-busy, mid-operation reset and the division invariant.
module tb_seq_div_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        calc_finished;
    logic        div_by_zero;

    int n_pass = 0;
    int n_total = 0;

    seq_div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .calc_finished(calc_finished),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Drives one operation; reports status right after the accept edge and the result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz,
                          output logic busy_acc, output logic cf_acc, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = a ^ b;
        busy_acc = busy;
        cf_acc   = calc_finished;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (calc_finished) begin
                lat = i;
                break;
            end
        end
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({quotient, remainder, busy, calc_finished, div_by_zero} !== 67'd0) begin
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b cf=%b dbz=%b, want all zero",
                     quotient, remainder, busy, calc_finished, div_by_zero);
        end else n_pass++;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_basic();
        logic stable_ok;
        int   lat;
        stable_ok = 1'b1;
        lat = -1;
        @(negedge clk);
        dividend = 32'd97;
        divisor  = 32'd30;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || calc_finished !== 1'b0) begin
            $display("FAIL basic_accept: got busy=%b cf=%b, want busy=1 cf=0", busy, calc_finished);
        end else n_pass++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (calc_finished) begin
                lat = i;
                break;
            end
            if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b1) stable_ok = 1'b0;
        end
        n_total++;
        if (!stable_ok) $display("FAIL basic_outputs_during_iter: got changed outputs or busy drop, want q=r=0 busy=1");
        else n_pass++;
        n_total++;
        if (lat !== 33) $display("FAIL basic_latency: got %0d, want 33", lat);
        else n_pass++;
        n_total++;
        if (quotient !== 32'd3 || remainder !== 32'd7 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_result: got q=%h r=%h dbz=%b busy=%b, want q=3 r=7 dbz=0 busy=0",
                     quotient, remainder, div_by_zero, busy);
        end else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (quotient !== 32'd3 || remainder !== 32'd7 || calc_finished !== 1'b1) begin
            $display("FAIL basic_done_hold: got q=%h r=%h cf=%b, want q=3 r=7 cf=1",
                     quotient, remainder, calc_finished);
        end else n_pass++;
    endtask

    task automatic test_signs();
        logic [31:0] va [4] = '{32'hFFFF_FF9F, 32'd97,         32'hFFFF_FF9F, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'd30,        32'hFFFF_FFE2, 32'hFFFF_FFE2, 32'h0000_0002};
        logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,         32'hC000_0000};
        logic [31:0] er [4] = '{32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFF9, 32'd0};
        logic [31:0] q, r;
        logic dbz, ba, ca;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], q, r, dbz, ba, ca, lat);
            n_total++;
            if (q !== eq[i] || r !== er[i] || dbz !== 1'b0 || lat !== 33 || ca !== 1'b0) begin
                $display("FAIL signs_%0d: got q=%h r=%h dbz=%b lat=%0d cf_at_accept=%b, want q=%h r=%h dbz=0 lat=33 cf_at_accept=0",
                         i, q, r, dbz, lat, ca, eq[i], er[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r;
        logic dbz, ba, ca;
        int lat;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, dbz, ba, ca, lat);
        n_total++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || dbz !== 1'b0 || lat !== 33) begin
            $display("FAIL overflow: got q=%h r=%h dbz=%b lat=%0d, want q=80000000 r=0 dbz=0 lat=33",
                     q, r, dbz, lat);
        end else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        logic dbz, ba, ca;
        int lat;
        run_op(32'd5, 32'd0, q, r, dbz, ba, ca, lat);
        n_total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dbz !== 1'b1 || lat !== 1 || ba !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL div_zero: got q=%h r=%h dbz=%b lat=%0d busy_acc=%b busy=%b, want q=ffffffff r=5 dbz=1 lat=1 busy_acc=1 busy=0",
                     q, r, dbz, lat, ba, busy);
        end else n_pass++;
        run_op(32'd6, 32'd3, q, r, dbz, ba, ca, lat);
        n_total++;
        if (q !== 32'd2 || r !== 32'd0 || dbz !== 1'b0 || lat !== 33) begin
            $display("FAIL div_zero_recover: got q=%h r=%h dbz=%b lat=%0d, want q=2 r=0 dbz=0 lat=33",
                     q, r, dbz, lat);
        end else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int lat;
        lat = -1;
        @(negedge clk);
        dividend = 32'd97;
        divisor  = 32'd30;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                dividend = 32'd1000;
                divisor  = 32'd7;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (calc_finished) begin
                lat = i;
                break;
            end
        end
        n_total++;
        if (quotient !== 32'd3 || remainder !== 32'd7 || lat !== 33) begin
            $display("FAIL start_while_busy: got q=%h r=%h lat=%0d, want q=3 r=7 lat=33",
                     quotient, remainder, lat);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_iter();
        logic [31:0] q, r;
        logic dbz, ba, ca, seen;
        int lat;
        @(negedge clk);
        dividend = 32'd97;
        divisor  = 32'd30;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        n_total++;
        if ({quotient, remainder, busy, calc_finished, div_by_zero} !== 67'd0) begin
            $display("FAIL reset_mid_iter: got q=%h r=%h busy=%b cf=%b dbz=%b, want all zero",
                     quotient, remainder, busy, calc_finished, div_by_zero);
        end else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (calc_finished || busy) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL reset_abort: got activity after reset, want idle");
        else n_pass++;
        run_op(32'd7, 32'd2, q, r, dbz, ba, ca, lat);
        n_total++;
        if (q !== 32'd3 || r !== 32'd1 || lat !== 33 || dbz !== 1'b0) begin
            $display("FAIL after_reset_op: got q=%h r=%h lat=%0d dbz=%b, want q=3 r=1 lat=33 dbz=0",
                     q, r, lat, dbz);
        end else n_pass++;
    endtask

    task automatic test_random_sweep();
        logic [31:0] a, b, q, r, recon;
        logic dbz, ba, ca;
        int lat;
        longint sa, sb, sr, mag_b, mag_r;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (b == 32'd0) b = 32'd1;
            run_op(a, b, q, r, dbz, ba, ca, lat);
            recon = q * b + r;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sr = longint'($signed(r));
            mag_b = (sb < 0) ? -sb : sb;
            mag_r = (sr < 0) ? -sr : sr;
            n_total++;
            if (recon !== a || mag_r >= mag_b || (sr != 0 && ((sr < 0) != (sa < 0))) ||
                lat !== 33 || dbz !== 1'b0) begin
                $display("FAIL sweep_%0d: a=%h b=%h got q=%h r=%h lat=%0d dbz=%b, want q*b+r==a |r|<|b| sign(r)=sign(a) lat=33",
                         n, a, b, q, r, lat, dbz);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_iter();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
